hms_readout: RTL and testbench
==============================

Name: hms_readout

Overview:
Read-side port of the hours/minutes/seconds timekeeper. On request it takes an atomic snapshot of hrs/min/sec and returns one field, or all three, to a downstream consumer over a valid/ready handshake. A per-field timeout aborts the transfer if the consumer stalls, so a dead reader cannot hang the block. It sits beside the timekeeper, which owns the write path (din/addr/load), and feeds display, debug or host logic.

Parameters:
TIMEOUT, 16, max cycles dout_valid may wait for ready per field before abort; 0 disables timeout.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
hrs  input  5  live hours value (0-23) from timekeeper
min  input  6  live minutes value (0-59)
sec  input  6  live seconds value (0-59)
rd_req  input  1  read request, sampled only in IDLE
addr  input  2  field select: 00 hrs, 01 min, 10 sec, 11 all (hrs, min, sec in order)
ready  input  1  consumer accepts dout this cycle
dout  output  6  field value; hrs zero-extended to 6 bits
dout_addr  output  2  code of field on dout (00/01/10)
dout_valid  output  1  dout/dout_addr valid
busy  output  1  high in any state other than IDLE
timeout_err  output  1  one-cycle pulse on abort

Behaviour:
- Reset (rst=0, async): state IDLE. dout=0, dout_addr=0, dout_valid=0, busy=0, timeout_err=0. Snapshot and timeout counter cleared. Reset mid-transfer drops the transfer silently with no error pulse.
- States: IDLE, SEND.
- IDLE: on a clock edge with rd_req=1, capture hrs/min/sec into snapshot registers on the same edge, latch the mode (single/all), load the first field and go to SEND. dout_valid is high from the next cycle (1-cycle latency). ready is ignored in IDLE.
- SEND: dout_valid=1. dout/dout_addr are held stable while ready=0.
  - Transfer happens on an edge with dout_valid && ready.
  - Single mode: after the transfer, go to IDLE and set dout_valid=0.
  - All mode: hrs -> min -> sec. The next field is presented the cycle after each transfer, back-to-back, with no valid gap. After sec transfers, go to IDLE.
- Snapshot is coherent. Changes on hrs/min/sec after capture do not affect the transfer; all three fields come from the same capture edge.
- rd_req while busy is ignored and not queued. rd_req on the edge completing the last transfer is also ignored; the request must be re-presented in IDLE.
- Timeout counter, width clog2(TIMEOUT+1):
  - Clears on entry to SEND and on each transfer.
  - Increments each SEND cycle with ready=0.
  - When the count reaches TIMEOUT with ready still 0: pulse timeout_err for 1 cycle, set dout_valid=0, go to IDLE. Remaining fields are discarded.
- Simultaneous ready and timeout on the same edge: ready wins; the field transfers and no error is raised.
- TIMEOUT=0: counter inactive; SEND waits indefinitely.
- dout holds its last value in IDLE; consumers must qualify it with dout_valid.

Decomposition:
- Shared package hms_pkg holds:
  - field codes ADDR_HRS=2'b00, ADDR_MIN=2'b01, ADDR_SEC=2'b10, ADDR_ALL=2'b11;
  - state encoding IDLE/SEND;
  - field widths HRS_W=5, MS_W=6.
- One natural sub-module: hms_timeout_ctr (parameter TIMEOUT; inputs clr, en; output expired), reusable by other handshake blocks. The FSM and snapshot stay in hms_readout.

Test Plan:
1. Reset mid-SEND (rst low 2 cycles) -> all outputs 0 immediately (async), no timeout_err; next rd_req works normally.
2. hrs=13, min=45, sec=07; rd_req with addr=01, ready=1 -> next cycle dout=45, dout_addr=01, dout_valid=1 for 1 cycle, then IDLE; busy high for 1 cycle.
3. Snapshot coherence: addr=11, ready held 0 for 3 cycles while sec changes 59->00 and min 12->13 -> outputs 12, 12 then 59 (captured values); 3 transfers back-to-back once ready=1; dout_addr sequence 00, 01, 10.
4. TIMEOUT=16, addr=10, ready never asserted -> dout_valid high 16 cycles, then timeout_err pulse 1 cycle, IDLE, busy=0.
5. TIMEOUT=16, ready asserted on exactly the expiry cycle -> field transfers, no timeout_err. In all mode, per-field count restarts: 15 stall cycles on each field, no error.
6. rd_req pulses while busy and on the final-transfer edge -> ignored; exactly one transfer sequence observed; rd_req with ready=1 in IDLE produces nothing extra.

Source files
------------

// File: rtl/hms_pkg.sv
// hms_pkg: shared definitions for the hours/minutes/seconds read side.
//   Field codes used on addr/dout_addr, FSM state encoding, field widths,
//   and a helper that selects one field and zero-extends it to the bus width.
package hms_pkg;

  localparam int HRS_W = 5;
  localparam int MS_W  = 6;

  localparam logic [1:0] ADDR_HRS = 2'b00;
  localparam logic [1:0] ADDR_MIN = 2'b01;
  localparam logic [1:0] ADDR_SEC = 2'b10;
  localparam logic [1:0] ADDR_ALL = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } hms_state_t;

  // Returns the field named by code; hours are zero-extended to MS_W bits.
  function automatic logic [MS_W-1:0] pick_field(
    input logic [1:0]       code,
    input logic [HRS_W-1:0] h,
    input logic [MS_W-1:0]  m,
    input logic [MS_W-1:0]  s
  );
    logic [MS_W-1:0] f;
    case (code)
      ADDR_MIN: f = m;
      ADDR_SEC: f = s;
      default:  f = {{(MS_W-HRS_W){1'b0}}, h};
    endcase
    return f;
  endfunction

endpackage

// File: rtl/hms_timeout_ctr.sv
// hms_timeout_ctr: stall watchdog for a valid/ready handshake.
//   clk     : system clock, rising edge
//   rst     : asynchronous active-low reset
//   clr     : restart the count (idle or on each completed transfer)
//   en      : one stalled cycle has elapsed this cycle
//   expired : this is the last stalled cycle allowed; an edge with en still
//             high aborts the transfer. Never asserts when TIMEOUT is 0.
module hms_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  // The count equals the number of stalled cycles already behind us, so the
  // abort edge is the one closing the cycle where the count is TIMEOUT-1.
  localparam logic [CW-1:0] LIM = (TIMEOUT < 1) ? '0 : CW'(TIMEOUT - 1);
  localparam bit ACTIVE = (TIMEOUT > 0);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && ACTIVE && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = ACTIVE && en && (cnt == LIM);

endmodule

// File: rtl/hms_readout.sv
// hms_readout: read-side port of the hh:mm:ss timekeeper.
//   On rd_req (in IDLE) all three live fields are captured on the same edge;
//   one field, or hrs/min/sec in order, is then handed out over valid/ready.
//   A per-field stall watchdog drops the transfer if the consumer stalls.
// Ports:
//   clk, rst        : clock (rising edge), asynchronous active-low reset
//   hrs, min, sec   : live time from the timekeeper
//   rd_req, addr    : request and field select (00 hrs, 01 min, 10 sec, 11 all)
//   ready           : consumer accepts dout this cycle
//   dout, dout_addr : presented field value and its code
//   dout_valid      : dout/dout_addr valid
//   busy            : transfer in progress
//   timeout_err     : one-cycle pulse when a stalled transfer is aborted
module hms_readout
  import hms_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [HRS_W-1:0] hrs,
  input  logic [MS_W-1:0]  min,
  input  logic [MS_W-1:0]  sec,
  input  logic             rd_req,
  input  logic [1:0]       addr,
  input  logic             ready,
  output logic [MS_W-1:0]  dout,
  output logic [1:0]       dout_addr,
  output logic             dout_valid,
  output logic             busy,
  output logic             timeout_err
);

  hms_state_t state, state_nxt;

  logic [HRS_W-1:0] snap_hrs;
  logic [MS_W-1:0]  snap_min;
  logic [MS_W-1:0]  snap_sec;
  logic             all_mode;

  logic       load;
  logic       xfer;
  logic       adv;
  logic       abort;
  logic       expired;
  logic [1:0] nxt_code;
  logic [1:0] first_code;

  assign nxt_code   = dout_addr + 2'd1;
  assign first_code = (addr == ADDR_ALL) ? ADDR_HRS : addr;

  hms_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    ((state == IDLE) || xfer),
    .en     ((state == SEND) && !ready),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    xfer      = 1'b0;
    adv       = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (rd_req) begin
          load      = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        // ready is checked before expiry so a transfer on the last allowed
        // cycle completes instead of aborting.
        if (ready) begin
          xfer = 1'b1;
          if (all_mode && (dout_addr != ADDR_SEC)) begin
            adv = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else if (expired) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture and field sequencing. The first field comes straight from the
  // live inputs so it matches the snapshot taken on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_hrs  <= '0;
      snap_min  <= '0;
      snap_sec  <= '0;
      all_mode  <= 1'b0;
      dout      <= '0;
      dout_addr <= '0;
    end else if (load) begin
      snap_hrs  <= hrs;
      snap_min  <= min;
      snap_sec  <= sec;
      all_mode  <= (addr == ADDR_ALL);
      dout_addr <= first_code;
      dout      <= pick_field(first_code, hrs, min, sec);
    end else if (adv) begin
      dout_addr <= nxt_code;
      dout      <= pick_field(nxt_code, snap_hrs, snap_min, snap_sec);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= abort;
    end
  end

  assign dout_valid = (state == SEND);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_hms_readout.sv
module tb_hms_readout;

  logic       clk;
  logic       rst;
  logic [4:0] hrs;
  logic [5:0] min;
  logic [5:0] sec;
  logic       rd_req;
  logic [1:0] addr;
  logic       ready;
  logic [5:0] dout;
  logic [1:0] dout_addr;
  logic       dout_valid;
  logic       busy;
  logic       timeout_err;

  int total;
  int bad;

  hms_readout #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .hrs        (hrs),
    .min        (min),
    .sec        (sec),
    .rd_req     (rd_req),
    .addr       (addr),
    .ready      (ready),
    .dout       (dout),
    .dout_addr  (dout_addr),
    .dout_valid (dout_valid),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    total++;
    if ({dout_valid, busy, timeout_err, dout_addr, dout} !== 11'd0) begin
      bad++;
      $display("FAIL reset_state: got %h want %h",
               {dout_valid, busy, timeout_err, dout_addr, dout}, 11'd0);
    end
  endtask

  task automatic test_reset_mid_send();
    hrs = 5'd9; min = 6'd8; sec = 6'd33;
    addr = 2'b00; rd_req = 1'b1; ready = 1'b0;
    tick();
    rd_req = 1'b0;
    total++;
    if ({busy, dout_valid, dout} !== {1'b1, 1'b1, 6'd9}) begin
      bad++;
      $display("FAIL rst_pre_busy: got %h want %h", {busy, dout_valid, dout}, {1'b1, 1'b1, 6'd9});
    end
    rst = 1'b0;
    #1;
    total++;
    if ({dout_valid, busy, timeout_err, dout_addr, dout} !== 11'd0) begin
      bad++;
      $display("FAIL rst_async: got %h want %h",
               {dout_valid, busy, timeout_err, dout_addr, dout}, 11'd0);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if ({timeout_err, busy, dout_valid} !== 3'b000) begin
        bad++;
        $display("FAIL rst_hold: got %b want 000", {timeout_err, busy, dout_valid});
      end
    end
    rst = 1'b1;
    tick();
    addr = 2'b10; rd_req = 1'b1; ready = 1'b1;
    tick();
    rd_req = 1'b0;
    total++;
    if ({dout_valid, dout_addr, dout} !== {1'b1, 2'b10, 6'd33}) begin
      bad++;
      $display("FAIL rst_after_read: got %h want %h", {dout_valid, dout_addr, dout}, {1'b1, 2'b10, 6'd33});
    end
    tick();
    ready = 1'b0;
    total++;
    if ({dout_valid, busy} !== 2'b00) begin
      bad++;
      $display("FAIL rst_after_idle: got %b want 00", {dout_valid, busy});
    end
  endtask

  task automatic test_single();
    hrs = 5'd13; min = 6'd45; sec = 6'd7;
    addr = 2'b01; rd_req = 1'b1; ready = 1'b1;
    tick();
    rd_req = 1'b0;
    total++;
    if ({dout_valid, busy, dout_addr, dout} !== {1'b1, 1'b1, 2'b01, 6'd45}) begin
      bad++;
      $display("FAIL single_min: got %h want %h", {dout_valid, busy, dout_addr, dout}, {1'b1, 1'b1, 2'b01, 6'd45});
    end
    tick();
    total++;
    if ({dout_valid, busy, timeout_err} !== 3'b000) begin
      bad++;
      $display("FAIL single_done: got %b want 000", {dout_valid, busy, timeout_err});
    end
    ready = 1'b0;
  endtask

  task automatic test_snapshot();
    hrs = 5'd12; min = 6'd12; sec = 6'd59;
    addr = 2'b11; rd_req = 1'b1; ready = 1'b0;
    tick();
    rd_req = 1'b0;
    sec = 6'd0; min = 6'd13;
    tick();
    tick();
    tick();
    total++;
    if ({dout_valid, dout_addr, dout} !== {1'b1, 2'b00, 6'd12}) begin
      bad++;
      $display("FAIL snap_hold_hrs: got %h want %h", {dout_valid, dout_addr, dout}, {1'b1, 2'b00, 6'd12});
    end
    ready = 1'b1;
    tick();
    total++;
    if ({dout_valid, dout_addr, dout} !== {1'b1, 2'b01, 6'd12}) begin
      bad++;
      $display("FAIL snap_min: got %h want %h", {dout_valid, dout_addr, dout}, {1'b1, 2'b01, 6'd12});
    end
    tick();
    total++;
    if ({dout_valid, dout_addr, dout} !== {1'b1, 2'b10, 6'd59}) begin
      bad++;
      $display("FAIL snap_sec: got %h want %h", {dout_valid, dout_addr, dout}, {1'b1, 2'b10, 6'd59});
    end
    tick();
    total++;
    if ({dout_valid, busy} !== 2'b00) begin
      bad++;
      $display("FAIL snap_done: got %b want 00", {dout_valid, busy});
    end
    ready = 1'b0;
  endtask

  task automatic test_timeout();
    int vcnt;
    int ecnt;
    vcnt = 0;
    ecnt = 0;
    sec = 6'd21; addr = 2'b10; rd_req = 1'b1; ready = 1'b0;
    tick();
    rd_req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (dout_valid) vcnt++;
      if (timeout_err) begin
        ecnt++;
        total++;
        if ({dout_valid, busy} !== 2'b00) begin
          bad++;
          $display("FAIL tmo_err_state: got %b want 00", {dout_valid, busy});
        end
      end
      tick();
    end
    total++;
    if (vcnt !== 16) begin
      bad++;
      $display("FAIL tmo_valid_cycles: got %0d want 16", vcnt);
    end
    total++;
    if (ecnt !== 1) begin
      bad++;
      $display("FAIL tmo_err_pulses: got %0d want 1", ecnt);
    end
    total++;
    if ({busy, dout_valid} !== 2'b00) begin
      bad++;
      $display("FAIL tmo_idle: got %b want 00", {busy, dout_valid});
    end
  endtask

  task automatic test_ready_at_expiry();
    int ecnt;
    logic [5:0] want [3];
    ecnt = 0;
    want[0] = 6'd7; want[1] = 6'd30; want[2] = 6'd44;
    // Single field: ready arrives on the cycle that would otherwise abort.
    min = 6'd30; addr = 2'b01; rd_req = 1'b1; ready = 1'b0;
    tick();
    rd_req = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (timeout_err) ecnt++;
    end
    total++;
    if ({dout_valid, dout} !== {1'b1, 6'd30}) begin
      bad++;
      $display("FAIL exp_single_valid: got %h want %h", {dout_valid, dout}, {1'b1, 6'd30});
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    total++;
    if ({dout_valid, busy, timeout_err} !== 3'b000) begin
      bad++;
      $display("FAIL exp_single_done: got %b want 000", {dout_valid, busy, timeout_err});
    end
    // All mode: 15 stalls on every field, count restarts per field.
    hrs = 5'd7; sec = 6'd44; addr = 2'b11; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 15; i++) begin
        tick();
        if (timeout_err) ecnt++;
      end
      total++;
      if ({dout_valid, dout_addr, dout} !== {1'b1, 2'(f), want[f]}) begin
        bad++;
        $display("FAIL exp_all_field%0d: got %h want %h", f, {dout_valid, dout_addr, dout}, {1'b1, 2'(f), want[f]});
      end
      ready = 1'b1;
      tick();
      if (timeout_err) ecnt++;
      ready = 1'b0;
    end
    total++;
    if ({dout_valid, busy} !== 2'b00) begin
      bad++;
      $display("FAIL exp_all_done: got %b want 00", {dout_valid, busy});
    end
    total++;
    if (ecnt !== 0) begin
      bad++;
      $display("FAIL exp_no_err: got %0d want 0", ecnt);
    end
  endtask

  task automatic test_back_to_back();
    int vcnt;
    hrs = 5'd3; min = 6'd4; sec = 6'd5;
    addr = 2'b11; rd_req = 1'b1; ready = 1'b0;
    tick();
    addr = 2'b01;
    tick();
    tick();
    total++;
    if ({dout_valid, dout_addr, dout} !== {1'b1, 2'b00, 6'd3}) begin
      bad++;
      $display("FAIL b2b_busy_req: got %h want %h", {dout_valid, dout_addr, dout}, {1'b1, 2'b00, 6'd3});
    end
    ready = 1'b1;
    tick();
    total++;
    if ({dout_valid, dout_addr, dout} !== {1'b1, 2'b01, 6'd4}) begin
      bad++;
      $display("FAIL b2b_min: got %h want %h", {dout_valid, dout_addr, dout}, {1'b1, 2'b01, 6'd4});
    end
    tick();
    total++;
    if ({dout_valid, dout_addr, dout} !== {1'b1, 2'b10, 6'd5}) begin
      bad++;
      $display("FAIL b2b_sec: got %h want %h", {dout_valid, dout_addr, dout}, {1'b1, 2'b10, 6'd5});
    end
    // rd_req is still high on the final transfer edge and must be dropped.
    tick();
    rd_req = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (dout_valid || busy) vcnt++;
      tick();
    end
    total++;
    if (vcnt !== 0) begin
      bad++;
      $display("FAIL b2b_no_requeue: got %0d want 0", vcnt);
    end
    addr = 2'b00; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    total++;
    if ({dout_valid, dout_addr, dout} !== {1'b1, 2'b00, 6'd3}) begin
      bad++;
      $display("FAIL b2b_idle_read: got %h want %h", {dout_valid, dout_addr, dout}, {1'b1, 2'b00, 6'd3});
    end
    vcnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (dout_valid) vcnt++;
    end
    total++;
    if (vcnt !== 0) begin
      bad++;
      $display("FAIL b2b_single_extra: got %0d want 0", vcnt);
    end
    ready = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    hrs = '0; min = '0; sec = '0;
    rd_req = 1'b0; addr = 2'b00; ready = 1'b0;
    tick();
    tick();
    test_reset();
    rst = 1'b1;
    tick();
    test_reset_mid_send();
    test_single();
    test_snapshot();
    test_timeout();
    test_ready_at_expiry();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
